clkgen_ctrl: RTL and testbench
==============================

# clkgen_ctrl

Run-time controller for the lab clock generator. Produces a divided clock `clk_o` from `clk_i` with a programmable half-period. It supports glitch-free start, stop and divide-ratio reloads, so stepper-motor and display labs can change output frequency without a reset. The divide value uses the same encoding as the generator's `DIVIDE` parameter (half-period cycles minus 1), and it is loaded through a single-entry request/acknowledge port.

## Interface
- `WIDTH`, 16, width of the divide value.
- `RESET_DIV`, 0, divide value after reset. Half-period = `RESET_DIV`+1 cycles of `clk_i`.

Ports:
- `clk_i` in 1: system clock; all state updates on its rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `en_i` in 1: level enable; 1 = run the output clock, 0 = stop it cleanly.
- `load_i` in 1: request to load `div_i`.
- `div_i` in `WIDTH`: new divide value, sampled when the request is captured.
- `load_ack_o` out 1: one-cycle pulse on the edge where the new value becomes active.
- `clk_o` out 1: divided clock, registered.
- `tick_o` out 1: one-cycle pulse coincident with each 0→1 transition of `clk_o`.
- `running_o` out 1: high when state ≠ IDLE.
- `div_o` out `WIDTH`: active divide value `div_q`.

## Operation
- Registers:
  - `state` ∈ {IDLE, RUN, STOPPING}
  - `cnt` (`WIDTH`)
  - `div_q` (`WIDTH`)
  - `pend_q` (1) and `pend_div` (`WIDTH`)
  - `clk_o`, `tick_o`, `load_ack_o`
- Reset (asynchronous, while `rst_ni`=0):
  - state=IDLE, cnt=0, div_q=`RESET_DIV`, pend_q=0.
  - clk_o=0, tick_o=0, load_ack_o=0, running_o=0, div_o=`RESET_DIV`.
- Counting, in RUN and STOPPING only:
  - If cnt==div_q: toggle clk_o and set cnt=0.
  - Otherwise: cnt=cnt+1.
  - Result: the output period is 2·(div_q+1) cycles at 50 % duty.
- IDLE:
  - clk_o=0 and cnt=0.
  - en_i=1 → RUN.
- RUN:
  - en_i=0 with clk_o=0 → IDLE on the next edge; cnt is cleared.
  - en_i=0 with clk_o=1 → STOPPING.
- STOPPING:
  - Keeps counting until clk_o toggles 1→0, then goes to IDLE on that same edge.
  - en_i=1 → back to RUN with no interruption to counting.
  - The high phase is never truncated.
- Load capture:
  - When load_i=1 and pend_q=0: pend_q=1 and pend_div=div_i.
  - load_i is ignored while pend_q=1, including a capture request on the same edge as an apply.
- Load apply, which sets div_q=pend_div, pend_q=0 and pulses load_ack_o=1 for one cycle:
  - In IDLE: on the edge after capture.
  - In RUN or STOPPING: on the edge where clk_o toggles 1→0, when cnt resets. The new value therefore governs whole half-periods only.
- tick_o is set on the edge where clk_o goes 0→1 and is cleared on the next edge.

## Timing
- Start latency: en_i sampled 1 at edge k in IDLE → RUN after k, cnt=0. clk_o first rises at edge k+div_q+1.
- div_q=0 gives `clk_o` = `clk_i`/2. The maximum divide value gives a half-period of 2^`WIDTH` cycles.
- cnt compares with `==` only. A smaller value is never loaded mid-phase, so no wrap-around case exists.
- Load ack latency: 1 cycle in IDLE; at most 2·(div_q+1) cycles in RUN or STOPPING.
- Stop latency from en_i=0:
  - 1 cycle if clk_o=0.
  - Otherwise the remaining high-phase cycles.
- Simultaneous en_i=0 and pending apply on the falling toggle: both take effect. The state goes to IDLE with the new div_q, and ack pulses.
- rst_ni asserted mid-operation:
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - Any pending load is discarded with no ack.

## Test plan
- Reset: run with div=0 and pull rst_ni low while clk_o=1 → clk_o, tick_o, running_o and load_ack_o are 0 immediately, and div_o=`RESET_DIV`.
- Basic division: `RESET_DIV`=0, 10 ns clk_i, en_i=1 at t=30 → clk_o has a 20 ns period, tick_o is high 1 cycle in every 2, and running_o=1.
- Run-time reload: running with div=0, load_i=1 with div_i=2 while clk_o=1 → load_ack_o pulses on the next 1→0 toggle, div_o=2, and the following phases are 3 cycles each (period 6).
- Clean stop: div=3, en_i=0 one cycle after clk_o rises → clk_o stays high its full 4 cycles, falls, and running_o=0 on that edge. No extra tick_o occurs.
- IDLE load and ignored second request: in IDLE, load_i with div_i=5 → ack 1 cycle after capture and div_o=5. In RUN, load 7 then load 9 before the ack → only 7 is applied, with one ack.
- Re-enable during STOPPING: en_i 1→0→1 while clk_o=1 → running_o stays 1 and the clk_o period is unchanged.

Source files
------------

// File: rtl/clkgen_ctrl.sv
// Purpose: run-time divided-clock generator with glitch-free start/stop and divide-ratio reloads.
// Latency: clk_o first rises div_q+1 cycles after RUN entry; reload applies on the next 1->0 toggle (next edge in IDLE).
// Backpressure: single-entry load port; further load_i requests are ignored until load_ack_o retires the pending one.
module clkgen_ctrl #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_DIV = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] div_i,
   output logic             load_ack_o,
   output logic             clk_o,
   output logic             tick_o,
   output logic             running_o,
   output logic [WIDTH-1:0] div_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] div_q;
   logic             pend_q;
   logic [WIDTH-1:0] pend_div_q;
   logic             clk_q;
   logic             tick_q;
   logic             ack_q;

   logic             count_en;
   logic             at_end;
   logic             toggle;
   logic             rise;
   logic             fall;
   logic             apply;

   // Phase bookkeeping: when the counter advances, when clk_o toggles, and when a pending load lands.
   always_comb begin
      count_en = 1'b0;
      at_end   = (cnt_q == div_q);
      toggle   = 1'b0;
      rise     = 1'b0;
      fall     = 1'b0;
      apply    = 1'b0;
      // A RUN request to stop while low goes straight to IDLE without counting.
      if (state_q == STOPPING) begin
         count_en = 1'b1;
      end else if (state_q == RUN) begin
         count_en = en_i | clk_q;
      end
      toggle = count_en & at_end;
      rise   = toggle & ~clk_q;
      fall   = toggle & clk_q;
      // New ratios only take effect at a half-period boundary, or immediately when idle.
      apply  = pend_q & ((state_q == IDLE) | fall);
   end

   // Control FSM plus counter, output clock, strobes and the load port.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         div_q      <= RESET_DIV;
         pend_q     <= 1'b0;
         pend_div_q <= '0;
         clk_q      <= 1'b0;
         tick_q     <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         tick_q <= rise;
         ack_q  <= apply;

         // Capture is refused while an entry is pending, even on the apply edge.
         if (apply) begin
            div_q  <= pend_div_q;
            pend_q <= 1'b0;
         end else if (load_i && !pend_q) begin
            pend_q     <= 1'b1;
            pend_div_q <= div_i;
         end

         case (state_q)
            IDLE: begin
               clk_q <= 1'b0;
               cnt_q <= '0;
               if (en_i) begin
                  state_q <= RUN;
               end
            end
            RUN, STOPPING: begin
               if (count_en) begin
                  if (at_end) begin
                     clk_q <= ~clk_q;
                     cnt_q <= '0;
                  end else begin
                     cnt_q <= cnt_q + WIDTH'(1);
                  end
               end else begin
                  clk_q <= 1'b0;
                  cnt_q <= '0;
               end

               if (en_i) begin
                  state_q <= RUN;
               end else if (state_q == RUN) begin
                  // Low phase stops at once; high phase is allowed to finish.
                  state_q <= (!clk_q || fall) ? IDLE : STOPPING;
               end else if (fall) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               clk_q   <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign clk_o      = clk_q;
   assign tick_o     = tick_q;
   assign load_ack_o = ack_q;
   assign running_o  = (state_q != IDLE);
   assign div_o      = div_q;

endmodule

// File: tb/tb_clkgen_ctrl.sv
// Purpose: randomized and directed stimulus for clkgen_ctrl against a phase-level reference model.
// Latency: inputs change on the falling edge, outputs compared on the following falling edge.
// Backpressure: none; the bench models the single-entry load port itself.
module tb_clkgen_ctrl;
   localparam int W = 16;

   logic         clk_i  = 1'b0;
   logic         rst_ni = 1'b0;
   logic         en_i   = 1'b0;
   logic         load_i = 1'b0;
   logic [W-1:0] div_i  = '0;
   logic         load_ack_o;
   logic         clk_o;
   logic         tick_o;
   logic         running_o;
   logic [W-1:0] div_o;

   clkgen_ctrl #(.WIDTH(W), .RESET_DIV('0)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en_i       (en_i),
      .load_i     (load_i),
      .div_i      (div_i),
      .load_ack_o (load_ack_o),
      .clk_o      (clk_o),
      .tick_o     (tick_o),
      .running_o  (running_o),
      .div_o      (div_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: mode 0=idle 1=run 2=stopping, 'left' = cycles until the next toggle.
   int m_mode, m_left, m_div, m_pdiv;
   bit m_pend, m_lvl, m_tick, m_ack;

   task automatic m_reset();
      m_mode = 0; m_left = 0; m_div = 0; m_pdiv = 0;
      m_pend = 0; m_lvl = 0; m_tick = 0; m_ack = 0;
   endtask

   task automatic m_apply();
      m_div  = m_pdiv;
      m_pend = 0;
      m_ack  = 1;
   endtask

   task automatic m_step(input bit en, input bit ld, input int dv);
      bit fell;
      bit had_pend;
      fell     = 0;
      had_pend = m_pend;
      m_tick   = 0;
      m_ack    = 0;
      if (m_mode == 0) begin
         if (m_pend) m_apply();
         m_lvl = 0;
         if (en) begin
            m_mode = 1;
            m_left = m_div + 1;
         end
      end else if (m_mode == 1 && !en && !m_lvl) begin
         m_mode = 0;
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_lvl = !m_lvl;
            if (m_lvl) m_tick = 1;
            else fell = 1;
            if (fell && m_pend) m_apply();
            m_left = m_div + 1;
         end
         if (en) m_mode = 1;
         else if (fell) m_mode = 0;
         else m_mode = 2;
      end
      if (ld && !had_pend) begin
         m_pend = 1;
         m_pdiv = dv;
      end
   endtask

   task automatic compare_all();
      check("clk_o", 32'(clk_o), 32'(m_lvl));
      check("tick_o", 32'(tick_o), 32'(m_tick));
      check("load_ack_o", 32'(load_ack_o), 32'(m_ack));
      check("running_o", 32'(running_o), 32'(m_mode != 0));
      check("div_o", 32'(div_o), 32'(m_div));
   endtask

   int tick_cnt = 0;

   // Called at a falling edge: drive, step through one rising edge, compare at the next falling edge.
   task automatic cycle(input bit en, input bit ld, input int dv);
      en_i   = en;
      load_i = ld;
      div_i  = W'(dv);
      @(posedge clk_i);
      m_step(en, ld, dv);
      @(negedge clk_i);
      compare_all();
      if (tick_o) tick_cnt++;
   endtask

   task automatic run_until_high(input bit en);
      for (int i = 0; i < 64 && !m_lvl; i++) cycle(en, 0, 0);
      check("reach_high", 32'(clk_o), 32'd1);
   endtask

   task automatic run_until_tick();
      for (int i = 0; i < 64 && !m_tick; i++) cycle(1, 0, 0);
      check("reach_tick", 32'(tick_o), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      m_reset();
      #12;
      check("rst_clk_o", 32'(clk_o), 32'd0);
      check("rst_running", 32'(running_o), 32'd0);
      check("rst_div_o", 32'(div_o), 32'd0);
      check("rst_ack", 32'(load_ack_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      cycle(0, 0, 0);

      // Basic division: div=0 -> one tick every two cycles
      tick_cnt = 0;
      for (int i = 0; i < 20; i++) cycle(1, 0, 0);
      check("basic_ticks", 32'(tick_cnt), 32'd10);

      // Asynchronous reset while clk_o high, with a load pending
      run_until_high(1);
      cycle(1, 1, 4);
      run_until_high(1);
      #2 rst_ni = 1'b0;
      #1;
      check("arst_clk_o", 32'(clk_o), 32'd0);
      check("arst_tick", 32'(tick_o), 32'd0);
      check("arst_running", 32'(running_o), 32'd0);
      check("arst_ack", 32'(load_ack_o), 32'd0);
      check("arst_div_o", 32'(div_o), 32'd0);
      m_reset();
      #1 rst_ni = 1'b1;
      @(negedge clk_i);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0);

      // Run-time reload to 2 while high
      for (int i = 0; i < 3; i++) cycle(1, 0, 0);
      run_until_high(1);
      cycle(1, 1, 2);
      for (int i = 0; i < 16; i++) cycle(1, 0, 0);

      // Clean stop with div=3, en dropped one cycle after the rise
      cycle(1, 1, 3);
      for (int i = 0; i < 12; i++) cycle(1, 0, 0);
      run_until_tick();
      cycle(1, 0, 0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 0);
      check("stopped", 32'(running_o), 32'd0);

      // IDLE load, then double request in RUN
      cycle(0, 1, 5);
      cycle(0, 0, 0);
      check("idle_load_div", 32'(div_o), 32'd5);
      cycle(1, 1, 7);
      cycle(1, 1, 9);
      for (int i = 0; i < 30; i++) cycle(1, 0, 0);
      check("run_load_div", 32'(div_o), 32'd7);

      // Re-enable during STOPPING
      run_until_high(1);
      cycle(0, 0, 0);
      cycle(1, 0, 0);
      for (int i = 0; i < 20; i++) cycle(1, 0, 0);

      // Randomized traffic
      begin
         bit en;
         en = 1;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) en = !en;
            cycle(en, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 4)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
